hdmi_link_manager: RTL

Parametrised HDMI link bring-up and supervision controller for the system-clock domain: debounces HPD, programs the optional NB7NQ621M retimer, negotiates HDMI 2.0 SCDC (source version, TMDS configuration) for a runtime-selected TMDS clock, then polls sink scrambler status and re-trains on loss. It drives an I2CMaster transaction port and emits the scrambler/bit-clock-ratio controls and `run` consumed by HDMISource in the TX domain through existing synchronisers. It adds debounce, bounded retries, runtime mode change, SCDC read-back supervision and a terminal fail state.

---
 rtl/hdmi_link_manager.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_link_manager.sv
// HDMI link bring-up and supervision: HPD debounce, retimer programming, SCDC
// negotiation for the selected TMDS clock, scrambler status polling and bounded re-training.
module hdmi_link_manager #(
  parameter logic [6:0] SCDC_ADDRESS         = 7'h54,
  parameter logic [6:0] RETIMER_ADDRESS      = 7'h5E,
  parameter bit         RETIMER_ENABLE       = 1'b1,
  parameter int         HPD_DEBOUNCE_CYCLES  = 1_000_000,
  parameter int         RETRY_DELAY_CYCLES   = 10_000_000,
  parameter int         POLL_INTERVAL_CYCLES = 25_000_000,
  parameter int         MAX_RETRIES          = 3
) (
  input  logic        system_clock,
  input  logic        system_reset,
  input  logic        hpd,
  input  logic [31:0] tmds_clock_frequency,
  input  logic        mode_change,
  output logic        i2c_ready,
  output logic [6:0]  i2c_address,
  output logic        i2c_rw,
  output logic [7:0]  i2c_register,
  output logic [7:0]  i2c_data_write,
  input  logic        i2c_valid,
  input  logic        i2c_nack,
  input  logic [7:0]  i2c_data_read,
  output logic        scrambler_enable,
  output logic        tmds_bit_clock_ratio,
  output logic        sink_hdmi_2_0,
  output logic        run,
  output logic        fail,
  output logic [3:0]  retry_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEBOUNCE, S_DELAY, S_CFG_RETIMER, S_SRC_VERSION,
    S_TMDS_CFG, S_RUN, S_POLL, S_FAIL
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cmd_t;

  localparam logic [31:0] DEBOUNCE_LOAD = 32'(HPD_DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] DELAY_LOAD    = 32'(RETRY_DELAY_CYCLES - 1);
  localparam logic [31:0] POLL_LOAD     = 32'(POLL_INTERVAL_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT   = 4'(MAX_RETRIES);
  localparam logic [31:0] OVER340_HZ    = 32'd340_000_000;

  function automatic cmd_t retimer_cmd(input logic [3:0] idx);
    logic [7:0] value;
    case (idx)
      4'd0:    value = 8'h0C;
      4'd1:    value = 8'h0F;
      4'd2:    value = 8'h00;
      4'd3:    value = 8'h30;
      4'd4:    value = 8'h03;
      4'd5:    value = 8'h30;
      4'd6:    value = 8'h03;
      4'd7:    value = 8'h0F;
      4'd8:    value = 8'hAA;
      default: value = 8'h00;
    endcase
    return '{addr: RETIMER_ADDRESS, rw: 1'b0, reg_addr: 8'h0A + {4'b0, idx}, data: value};
  endfunction

  function automatic cmd_t scdc_write(input logic [7:0] reg_addr, input logic [7:0] value);
    return '{addr: SCDC_ADDRESS, rw: 1'b0, reg_addr: reg_addr, data: value};
  endfunction

  function automatic cmd_t scdc_read(input logic [7:0] reg_addr);
    return '{addr: SCDC_ADDRESS, rw: 1'b1, reg_addr: reg_addr, data: 8'h00};
  endfunction

  state_t      state;
  cmd_t        command;
  logic [31:0] counter;
  logic [3:0]  retimer_index;
  logic [3:0]  retry_next;
  logic        over340_now;
  logic        attempt_failed;
  logic        unused_read_bits;

  assign i2c_address      = command.addr;
  assign i2c_rw           = command.rw;
  assign i2c_register     = command.reg_addr;
  assign i2c_data_write   = command.data;
  assign retry_next       = retry_count + 4'd1;
  assign over340_now      = tmds_clock_frequency > OVER340_HZ;
  assign unused_read_bits = ^i2c_data_read[7:1];

  // scrambler_enable doubles as the latched over-340 MHz flag
  always_comb begin
    attempt_failed = 1'b0;
    if (i2c_valid) begin
      case (state)
        S_CFG_RETIMER, S_TMDS_CFG: attempt_failed = i2c_nack;
        S_SRC_VERSION:             attempt_failed = i2c_nack && scrambler_enable;
        S_POLL:                    attempt_failed = i2c_nack || !i2c_data_read[0];
        default:                   attempt_failed = 1'b0;
      endcase
    end
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state                <= S_IDLE;
      command              <= '0;
      counter              <= '0;
      retimer_index        <= '0;
      i2c_ready            <= 1'b0;
      scrambler_enable     <= 1'b0;
      tmds_bit_clock_ratio <= 1'b0;
      sink_hdmi_2_0        <= 1'b0;
      run                  <= 1'b0;
      fail                 <= 1'b0;
      retry_count          <= '0;
    end else if (state != S_IDLE && !hpd) begin
      state         <= S_IDLE;
      i2c_ready     <= 1'b0;
      run           <= 1'b0;
      fail          <= 1'b0;
      sink_hdmi_2_0 <= 1'b0;
    end else if (state != S_IDLE && mode_change) begin
      state                <= S_DELAY;
      counter              <= DELAY_LOAD;
      retry_count          <= '0;
      scrambler_enable     <= over340_now;
      tmds_bit_clock_ratio <= over340_now;
      i2c_ready            <= 1'b0;
      run                  <= 1'b0;
      fail                 <= 1'b0;
    end else if (attempt_failed) begin
      retry_count <= retry_next;
      i2c_ready   <= 1'b0;
      run         <= 1'b0;
      if (state == S_SRC_VERSION) sink_hdmi_2_0 <= 1'b0;
      if (retry_next >= RETRY_LIMIT) begin
        state <= S_FAIL;
        fail  <= 1'b1;
      end else begin
        state   <= S_DELAY;
        counter <= DELAY_LOAD;
      end
    end else begin
      case (state)
        S_IDLE: if (hpd) begin
          state       <= S_DEBOUNCE;
          counter     <= DEBOUNCE_LOAD;
          retry_count <= '0;
        end
        S_DEBOUNCE: if (counter == '0) begin
          scrambler_enable     <= over340_now;
          tmds_bit_clock_ratio <= over340_now;
          state                <= S_DELAY;
          counter              <= DELAY_LOAD;
        end else counter <= counter - 32'd1;
        S_DELAY: if (counter == '0) begin
          i2c_ready <= 1'b1;
          if (RETIMER_ENABLE) begin
            state         <= S_CFG_RETIMER;
            retimer_index <= '0;
            command       <= retimer_cmd(4'd0);
          end else begin
            state   <= S_SRC_VERSION;
            command <= scdc_write(8'h02, 8'h01);
          end
        end else counter <= counter - 32'd1;
        S_CFG_RETIMER: if (i2c_valid) begin
          if (retimer_index == 4'd8) begin
            state   <= S_SRC_VERSION;
            command <= scdc_write(8'h02, 8'h01);
          end else begin
            retimer_index <= retimer_index + 4'd1;
            command       <= retimer_cmd(retimer_index + 4'd1);
          end
        end
        S_SRC_VERSION: if (i2c_valid) begin
          if (!i2c_nack) begin
            sink_hdmi_2_0 <= 1'b1;
            state         <= S_TMDS_CFG;
            command       <= scdc_write(8'h20, {6'b0, tmds_bit_clock_ratio, scrambler_enable});
          end else begin
            // sink without SCDC is still usable below 340 MHz
            sink_hdmi_2_0 <= 1'b0;
            state         <= S_RUN;
            counter       <= POLL_LOAD;
            i2c_ready     <= 1'b0;
            run           <= 1'b1;
            retry_count   <= '0;
          end
        end
        S_TMDS_CFG: if (i2c_valid) begin
          state       <= S_RUN;
          counter     <= POLL_LOAD;
          i2c_ready   <= 1'b0;
          run         <= 1'b1;
          retry_count <= '0;
        end
        S_RUN: if (sink_hdmi_2_0 && scrambler_enable) begin
          if (counter == '0) begin
            state     <= S_POLL;
            i2c_ready <= 1'b1;
            command   <= scdc_read(8'h21);
          end else counter <= counter - 32'd1;
        end
        S_POLL: if (i2c_valid) begin
          state     <= S_RUN;
          counter   <= POLL_LOAD;
          i2c_ready <= 1'b0;
        end
        S_FAIL: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
